// File: rtl/alt_ddrx_ecc_encoder_pipe.sv
// Two-stage pipelined SECDED encoder for the DDRX write datapath (64->72 or 32->40).
// Optional error injection on the stage-2 codeword is enabled with ALT_DDRX_ECC_ERR_INJECT_EN.
module alt_ddrx_ecc_encoder_pipe #(
  parameter int unsigned INPUT_DATA_WIDTH  = 64,
  parameter int unsigned OUTPUT_DATA_WIDTH = 72
) (
  input  logic                         ctl_clk,
  input  logic                         ctl_reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_DATA_WIDTH-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
  output logic [31:0]                  enc_count
`ifdef ALT_DDRX_ECC_ERR_INJECT_EN
  ,
  input  logic                         err_inject_req,
  input  logic [OUTPUT_DATA_WIDTH-1:0] err_inject_mask
`endif
);

  localparam int unsigned IW = INPUT_DATA_WIDTH;
  localparam int unsigned OW = OUTPUT_DATA_WIDTH;
  localparam int unsigned CW = (IW == 64) ? 7 : 6;

  if (!((IW == 64 && OW == 72) || (IW == 32 && OW == 40))) begin : g_bad_width
    $error("alt_ddrx_ecc_encoder_pipe: width pair must be 64/72 or 32/40");
  end

  // Data bits that feed check bit ci: data bit k sits at the k-th non-power-of-two position from 3.
  function automatic logic [IW-1:0] chk_mask(input int unsigned ci);
    logic [IW-1:0] m;
    int unsigned   pos;
    m   = '0;
    pos = 3;
    for (int unsigned k = 0; k < IW; k++) begin
      if ((pos & (pos - 1)) == 0) pos++;
      m[k] = pos[ci];
      pos++;
    end
    return m;
  endfunction

  logic [CW-1:0] chk_c;
  for (genvar i = 0; i < CW; i++) begin : g_chk
    localparam logic [IW-1:0] MASK = chk_mask(i);
    assign chk_c[i] = ^(in_data & MASK);
  end

  logic          s1_valid;
  logic [IW-1:0] s1_data;
  logic [CW-1:0] s1_chk;
  logic          s1_load_c;
  logic          s2_load_c;
  logic [OW-1:0] cw_c;
  logic [OW-1:0] inj_c;

  assign s2_load_c = out_ready || !out_valid;
  assign s1_load_c = s2_load_c || !s1_valid;
  assign in_ready  = s1_load_c;

  // Overall parity covers data and check bits; unused top bit of the 40-bit code stays 0.
  assign cw_c = OW'({^{s1_data, s1_chk}, s1_chk, s1_data});

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_chk   <= '0;
    end else if (s1_load_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_chk  <= chk_c;
      end
    end
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_load_c) begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= cw_c ^ inj_c;
    end
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      enc_count <= '0;
    end else if (out_valid && out_ready && (enc_count != 32'hFFFF_FFFF)) begin
      enc_count <= enc_count + 32'd1;
    end
  end

`ifdef ALT_DDRX_ECC_ERR_INJECT_EN
  logic          inj_armed;
  logic [OW-1:0] inj_mask;

  // A new request wins over the clear, so it re-arms for the word after the one being corrupted.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      inj_armed <= 1'b0;
      inj_mask  <= '0;
    end else if (err_inject_req) begin
      inj_armed <= 1'b1;
      inj_mask  <= err_inject_mask;
    end else if (s2_load_c && s1_valid) begin
      inj_armed <= 1'b0;
    end
  end

  assign inj_c = inj_armed ? inj_mask : '0;
`else
  assign inj_c = '0;
`endif

endmodule
